// File: rtl/keccak_stream_ctrl.sv
// Keccak accelerator controller: streams pre-padded rate blocks from dual-port RAM
// into the keccak core, then squeezes an arbitrary-length digest back into RAM.
module keccak_stream_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int LEN_WIDTH      = 16,
  parameter int MAX_RATE_LANES = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [4:0]              rate_lanes,
  input  logic [LEN_WIDTH-1:0]    in_blocks,
  input  logic [LEN_WIDTH-1:0]    out_bytes,
  input  logic [ADDR_WIDTH-1:0]   in_base,
  input  logic [ADDR_WIDTH-1:0]   out_base,
  output logic                    busy,
  output logic                    done,
  output logic                    error,
  output logic                    mem_en_a,
  output logic                    mem_en_b,
  output logic                    mem_we_a,
  output logic                    mem_we_b,
  output logic [ADDR_WIDTH-1:0]   mem_addr_a,
  output logic [ADDR_WIDTH-1:0]   mem_addr_b,
  output logic [DATA_WIDTH-1:0]   mem_wdata_a,
  output logic [DATA_WIDTH-1:0]   mem_wdata_b,
  output logic [DATA_WIDTH/8-1:0] mem_be_a,
  output logic [DATA_WIDTH/8-1:0] mem_be_b,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_a,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_b,
  output logic                    k_start,
  output logic [2*DATA_WIDTH-1:0] k_din,
  output logic                    k_din_valid,
  input  logic                    k_buffer_full,
  output logic                    k_last_block,
  input  logic                    k_ready,
  input  logic [2*DATA_WIDTH-1:0] k_dout,
  input  logic                    k_dout_valid,
  output logic                    k_squeeze
);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_ABSORB, S_WAIT_FULL, S_WAIT_PERM, S_SQUEEZE, S_DONE, S_ERROR
  } state_e;

  localparam logic [4:0]         MAX_RATE = 5'(MAX_RATE_LANES);
  localparam logic [LEN_WIDTH:0] FOUR     = (LEN_WIDTH+1)'(4);
  localparam logic [LEN_WIDTH:0] EIGHT    = (LEN_WIDTH+1)'(8);
  localparam int                 BW       = DATA_WIDTH/8;

  function automatic logic [BW-1:0] low_mask(input logic [2:0] n);
    case (n)
      3'd0:    low_mask = BW'(4'h0);
      3'd1:    low_mask = BW'(4'h1);
      3'd2:    low_mask = BW'(4'h3);
      3'd3:    low_mask = BW'(4'h7);
      default: low_mask = BW'(4'hF);
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic                    start_prev_q;
  logic [4:0]              rate_q, rate_d;
  logic [LEN_WIDTH-1:0]    in_blocks_q, in_blocks_d, out_bytes_q, out_bytes_d;
  logic [ADDR_WIDTH-1:0]   in_base_q, in_base_d, out_base_q, out_base_d;
  logic [ADDR_WIDTH-1:0]   rd_addr_q, rd_addr_d;
  logic [4:0]              lane_cnt_q, lane_cnt_d, sq_lane_q, sq_lane_d;
  logic [LEN_WIDTH-1:0]    blk_cnt_q, blk_cnt_d;
  logic [LEN_WIDTH:0]      byte_cnt_q, byte_cnt_d, rem;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d;
  logic                    en_a_q, en_a_d, en_b_q, en_b_d, we_a_q, we_a_d, we_b_q, we_b_d;
  logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
  logic [DATA_WIDTH-1:0]   wdata_a_q, wdata_a_d, wdata_b_q, wdata_b_d;
  logic [BW-1:0]           be_a_q, be_a_d, be_b_q, be_b_d;
  logic                    k_start_q, k_start_d, k_din_valid_q, k_din_valid_d;
  logic                    k_last_block_q, k_last_block_d, k_squeeze_q, k_squeeze_d;
  logic                    cfg_bad;

  always_comb begin
    state_d        = state_q;
    rate_d         = rate_q;
    in_blocks_d    = in_blocks_q;
    out_bytes_d    = out_bytes_q;
    in_base_d      = in_base_q;
    out_base_d     = out_base_q;
    rd_addr_d      = rd_addr_q;
    lane_cnt_d     = lane_cnt_q;
    sq_lane_d      = sq_lane_q;
    blk_cnt_d      = blk_cnt_q;
    byte_cnt_d     = byte_cnt_q;
    en_a_d         = 1'b0;
    en_b_d         = 1'b0;
    we_a_d         = 1'b0;
    we_b_d         = 1'b0;
    addr_a_d       = '0;
    addr_b_d       = '0;
    wdata_a_d      = '0;
    wdata_b_d      = '0;
    be_a_d         = '0;
    be_b_d         = '0;
    k_squeeze_d    = 1'b0;
    rem            = {1'b0, out_bytes_q} - byte_cnt_q;
    cfg_bad        = (rate_lanes == 5'd0) || (rate_lanes > MAX_RATE) ||
                     (in_blocks == '0) || (out_bytes == '0);
    case (state_q)
      S_IDLE: if (start && !start_prev_q) begin
        rate_d      = rate_lanes;
        in_blocks_d = in_blocks;
        out_bytes_d = out_bytes;
        in_base_d   = in_base;
        out_base_d  = out_base;
        state_d     = cfg_bad ? S_ERROR : S_INIT;
      end
      S_INIT: begin
        lane_cnt_d = '0;
        sq_lane_d  = '0;
        blk_cnt_d  = '0;
        byte_cnt_d = '0;
        rd_addr_d  = in_base_q;
        state_d    = S_ABSORB;
      end
      // Blocks are contiguous, so a running word address replaces blk*rate+lane.
      S_ABSORB: begin
        en_a_d     = 1'b1;
        en_b_d     = 1'b1;
        addr_a_d   = rd_addr_q;
        addr_b_d   = rd_addr_q + ADDR_WIDTH'(1);
        rd_addr_d  = rd_addr_q + ADDR_WIDTH'(2);
        lane_cnt_d = lane_cnt_q + 5'd1;
        if (lane_cnt_d == rate_q) state_d = S_WAIT_FULL;
      end
      S_WAIT_FULL: if (k_buffer_full) begin
        blk_cnt_d  = blk_cnt_q + LEN_WIDTH'(1);
        lane_cnt_d = '0;
        state_d    = (blk_cnt_d == in_blocks_q) ? S_WAIT_PERM : S_ABSORB;
      end
      S_WAIT_PERM: if (k_ready) state_d = S_SQUEEZE;
      S_SQUEEZE: if (k_dout_valid && (byte_cnt_q < {1'b0, out_bytes_q})) begin
        en_a_d    = 1'b1;
        we_a_d    = 1'b1;
        addr_a_d  = out_base_q + ADDR_WIDTH'(byte_cnt_q >> 2);
        addr_b_d  = out_base_q + ADDR_WIDTH'(byte_cnt_q >> 2) + ADDR_WIDTH'(1);
        wdata_a_d = k_dout[DATA_WIDTH-1:0];
        wdata_b_d = k_dout[2*DATA_WIDTH-1:DATA_WIDTH];
        be_a_d    = (rem >= FOUR) ? {BW{1'b1}} : low_mask(rem[2:0]);
        if (rem >= EIGHT) begin
          be_b_d = {BW{1'b1}};
          en_b_d = 1'b1;
        end else if (rem > FOUR) begin
          be_b_d = low_mask(rem[2:0] - 3'd4);
          en_b_d = 1'b1;
        end
        we_b_d     = en_b_d;
        byte_cnt_d = byte_cnt_q + EIGHT;
        sq_lane_d  = sq_lane_q + 5'd1;
        if (byte_cnt_d >= {1'b0, out_bytes_q}) begin
          state_d = S_DONE;
        end else if (sq_lane_d == rate_q) begin
          k_squeeze_d = 1'b1;
          sq_lane_d   = '0;
          state_d     = S_WAIT_PERM;
        end
      end
      S_DONE, S_ERROR: if (!start) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status and core strobes are derived from the next state so they line up with state_q.
    busy_d         = state_d inside {S_INIT, S_ABSORB, S_WAIT_FULL, S_WAIT_PERM, S_SQUEEZE};
    done_d         = state_d inside {S_DONE, S_ERROR};
    error_d        = (state_d == S_ERROR);
    k_start_d      = (state_d == S_INIT);
    k_last_block_d = (state_d inside {S_ABSORB, S_WAIT_FULL}) &&
                     (blk_cnt_d == in_blocks_q - LEN_WIDTH'(1));
    k_din_valid_d  = en_a_q && !we_a_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      start_prev_q   <= 1'b0;
      rate_q         <= '0;
      in_blocks_q    <= '0;
      out_bytes_q    <= '0;
      in_base_q      <= '0;
      out_base_q     <= '0;
      rd_addr_q      <= '0;
      lane_cnt_q     <= '0;
      sq_lane_q      <= '0;
      blk_cnt_q      <= '0;
      byte_cnt_q     <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
      en_a_q         <= 1'b0;
      en_b_q         <= 1'b0;
      we_a_q         <= 1'b0;
      we_b_q         <= 1'b0;
      addr_a_q       <= '0;
      addr_b_q       <= '0;
      wdata_a_q      <= '0;
      wdata_b_q      <= '0;
      be_a_q         <= '0;
      be_b_q         <= '0;
      k_start_q      <= 1'b0;
      k_din_valid_q  <= 1'b0;
      k_last_block_q <= 1'b0;
      k_squeeze_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      start_prev_q   <= start;
      rate_q         <= rate_d;
      in_blocks_q    <= in_blocks_d;
      out_bytes_q    <= out_bytes_d;
      in_base_q      <= in_base_d;
      out_base_q     <= out_base_d;
      rd_addr_q      <= rd_addr_d;
      lane_cnt_q     <= lane_cnt_d;
      sq_lane_q      <= sq_lane_d;
      blk_cnt_q      <= blk_cnt_d;
      byte_cnt_q     <= byte_cnt_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      error_q        <= error_d;
      en_a_q         <= en_a_d;
      en_b_q         <= en_b_d;
      we_a_q         <= we_a_d;
      we_b_q         <= we_b_d;
      addr_a_q       <= addr_a_d;
      addr_b_q       <= addr_b_d;
      wdata_a_q      <= wdata_a_d;
      wdata_b_q      <= wdata_b_d;
      be_a_q         <= be_a_d;
      be_b_q         <= be_b_d;
      k_start_q      <= k_start_d;
      k_din_valid_q  <= k_din_valid_d;
      k_last_block_q <= k_last_block_d;
      k_squeeze_q    <= k_squeeze_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign mem_en_a     = en_a_q;
  assign mem_en_b     = en_b_q;
  assign mem_we_a     = we_a_q;
  assign mem_we_b     = we_b_q;
  assign mem_addr_a   = addr_a_q;
  assign mem_addr_b   = addr_b_q;
  assign mem_wdata_a  = wdata_a_q;
  assign mem_wdata_b  = wdata_b_q;
  assign mem_be_a     = be_a_q;
  assign mem_be_b     = be_b_q;
  assign k_start      = k_start_q;
  // Read data lands one cycle after the enable, alongside the registered valid.
  assign k_din        = k_din_valid_q ? {mem_rdata_b, mem_rdata_a} : '0;
  assign k_din_valid  = k_din_valid_q;
  assign k_last_block = k_last_block_q;
  assign k_squeeze    = k_squeeze_q;

endmodule

// File: tb/tb_keccak_stream_ctrl.sv
// Directed bench for keccak_stream_ctrl with a behavioural RAM and a stub keccak core.
module tb_keccak_stream_ctrl;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [4:0]  rate_lanes = '0;
  logic [15:0] in_blocks = '0, out_bytes = '0;
  logic [31:0] in_base = '0, out_base = '0;
  logic        busy, done, error;
  logic        mem_en_a, mem_en_b, mem_we_a, mem_we_b;
  logic [31:0] mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b;
  logic [3:0]  mem_be_a, mem_be_b;
  logic [31:0] mem_rdata_a = '0, mem_rdata_b = '0;
  logic        k_start, k_din_valid, k_last_block, k_squeeze;
  logic [63:0] k_din;
  logic        k_buffer_full = 1'b0, k_ready = 1'b0, k_dout_valid = 1'b0;
  logic [63:0] k_dout = '0;

  always #5 clk = ~clk;

  keccak_stream_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .rate_lanes(rate_lanes),
    .in_blocks(in_blocks), .out_bytes(out_bytes), .in_base(in_base), .out_base(out_base),
    .busy(busy), .done(done), .error(error),
    .mem_en_a(mem_en_a), .mem_en_b(mem_en_b), .mem_we_a(mem_we_a), .mem_we_b(mem_we_b),
    .mem_addr_a(mem_addr_a), .mem_addr_b(mem_addr_b),
    .mem_wdata_a(mem_wdata_a), .mem_wdata_b(mem_wdata_b),
    .mem_be_a(mem_be_a), .mem_be_b(mem_be_b),
    .mem_rdata_a(mem_rdata_a), .mem_rdata_b(mem_rdata_b),
    .k_start(k_start), .k_din(k_din), .k_din_valid(k_din_valid),
    .k_buffer_full(k_buffer_full), .k_last_block(k_last_block),
    .k_ready(k_ready), .k_dout(k_dout), .k_dout_valid(k_dout_valid), .k_squeeze(k_squeeze)
  );

  int errors = 0, checks = 0;
  logic [31:0] mem [0:255];
  logic [31:0] pend_a, pend_b;
  logic [63:0] golden_lane [0:3];
  logic [31:0] golden_word [0:7];
  int cfg_rate, cfg_blocks, cfg_ib, use_golden;
  int n_rd, n_wr, n_en, n_kstart, n_ksq, n_din, din_bad, lb_bad, same_bad, max_wr;
  int lanes_in_blk, blk_idx, perm_delay, sq_stream, sq_idx;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pat(input int a);
    return 32'hC0DE_0000 + 32'(a);
  endfunction

  function automatic logic [63:0] lane_val(input int n);
    if (use_golden != 0 && n < 4) return golden_lane[n];
    return {32'hB000_0000 + 32'(n), 32'hA000_0000 + 32'(n)};
  endfunction

  function automatic logic [31:0] exp_word(input int w, input int outb, input int ob);
    logic [31:0] r;
    logic [63:0] lv;
    r = pat(ob + w);
    for (int k = 0; k < 4; k++) begin
      if (4*w + k < outb) begin
        lv = lane_val((4*w + k) / 8);
        r[8*k +: 8] = lv[8*((4*w + k) % 8) +: 8];
      end
    end
    return r;
  endfunction

  task automatic write_word(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    n_wr++;
    if (int'(a) > max_wr) max_wr = int'(a);
    for (int i = 0; i < 4; i++)
      if (be[i]) mem[a[7:0]][8*i +: 8] = d[8*i +: 8];
  endtask

  // One clock: present RAM read data, then observe the DUT and drive the core stub.
  task automatic cycle();
    @(posedge clk); #1;
    mem_rdata_a = pend_a;
    mem_rdata_b = pend_b;
    k_buffer_full = 1'b0;
    k_ready = 1'b0;
    k_dout_valid = 1'b0;
    k_dout = '0;
    #1;
    if (k_start) n_kstart++;
    if (mem_en_a || mem_en_b) n_en++;
    if (k_din_valid) begin
      if (k_din !== {pat(cfg_ib + 2*n_din + 1), pat(cfg_ib + 2*n_din)}) din_bad++;
      if (k_last_block !== (blk_idx == cfg_blocks - 1)) lb_bad++;
      n_din++;
      lanes_in_blk++;
      if (lanes_in_blk == cfg_rate) begin
        k_buffer_full = 1'b1;
        lanes_in_blk = 0;
        blk_idx++;
        if (blk_idx == cfg_blocks) perm_delay = 3;
      end
    end
    if (k_squeeze) begin n_ksq++; perm_delay = 3; end
    if (sq_stream > 0) begin
      k_dout_valid = 1'b1;
      k_dout = lane_val(sq_idx);
      sq_idx++;
      sq_stream--;
    end
    if (perm_delay == 0) begin
      k_ready = 1'b1;
      perm_delay = -1;
      sq_stream = cfg_rate;
    end else if (perm_delay > 0) perm_delay--;
    pend_a = '0;
    pend_b = '0;
    if (mem_en_a && !mem_we_a) begin n_rd++; pend_a = mem[mem_addr_a[7:0]]; end
    if (mem_en_b && !mem_we_b) pend_b = mem[mem_addr_b[7:0]];
    if (mem_en_a && mem_we_a && mem_en_b && mem_we_b && mem_addr_a == mem_addr_b) same_bad++;
    if (mem_en_a && mem_we_a) write_word(mem_addr_a, mem_wdata_a, mem_be_a);
    if (mem_en_b && mem_we_b) write_word(mem_addr_b, mem_wdata_b, mem_be_b);
  endtask

  task automatic setup_job(input int rate, input int blocks, input int outb,
                           input int ib, input int ob, input int gold);
    rate_lanes = 5'(rate); in_blocks = 16'(blocks); out_bytes = 16'(outb);
    in_base = 32'(ib); out_base = 32'(ob);
    cfg_rate = rate; cfg_blocks = blocks; cfg_ib = ib; use_golden = gold;
    n_rd = 0; n_wr = 0; n_en = 0; n_kstart = 0; n_ksq = 0; n_din = 0;
    din_bad = 0; lb_bad = 0; same_bad = 0; max_wr = -1;
    lanes_in_blk = 0; blk_idx = 0; perm_delay = -1; sq_stream = 0; sq_idx = 0;
    pend_a = '0; pend_b = '0;
    for (int i = 0; i < 256; i++) mem[i] = pat(i);
  endtask

  task automatic run_job(input int rate, input int blocks, input int outb,
                         input int ib, input int ob, input int gold, input int abort5);
    setup_job(rate, blocks, outb, ib, ob, gold);
    start = 1'b0;
    cycle();
    start = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      if (abort5 != 0 && n_rd == 6) break;
      if (done) break;
    end
  endtask

  task automatic check_job(input string p, input int exp_rd, input int exp_sq,
                           input int exp_words, input int ob, input int outb);
    int bad;
    chk({p, "_done"}, 64'(done), 64'(1));
    chk({p, "_busy"}, 64'(busy), 64'(0));
    chk({p, "_error"}, 64'(error), 64'(0));
    chk({p, "_kstart"}, 64'(n_kstart), 64'(1));
    chk({p, "_reads"}, 64'(n_rd), 64'(exp_rd));
    chk({p, "_din_cnt"}, 64'(n_din), 64'(exp_rd));
    chk({p, "_din_data"}, 64'(din_bad), 64'(0));
    chk({p, "_last_blk"}, 64'(lb_bad), 64'(0));
    chk({p, "_squeezes"}, 64'(n_ksq), 64'(exp_sq));
    chk({p, "_writes"}, 64'(n_wr), 64'(exp_words));
    chk({p, "_max_addr"}, 64'(max_wr), 64'(ob + exp_words - 1));
    chk({p, "_same_addr"}, 64'(same_bad), 64'(0));
    bad = 0;
    for (int w = 0; w < exp_words; w++)
      if (mem[ob + w] !== exp_word(w, outb, ob)) bad++;
    chk({p, "_digest"}, 64'(bad), 64'(0));
    chk({p, "_no_overrun"}, 64'(mem[ob + exp_words]), 64'(pat(ob + exp_words)));
    $display("job %s: reads=%0d writes=%0d squeezes=%0d", p, n_rd, n_wr, n_ksq);
  endtask

  task automatic err_job(input string p, input int rate, input int blocks, input int outb);
    setup_job(rate, blocks, outb, 16, 160, 0);
    start = 1'b0;
    cycle();
    start = 1'b1;
    repeat (5) cycle();
    chk({p, "_error"}, 64'(error), 64'(1));
    chk({p, "_done"}, 64'(done), 64'(1));
    chk({p, "_busy"}, 64'(busy), 64'(0));
    chk({p, "_mem_en"}, 64'(n_en), 64'(0));
    chk({p, "_kstart"}, 64'(n_kstart), 64'(0));
    start = 1'b0;
    repeat (2) cycle();
    chk({p, "_error_clr"}, 64'(error), 64'(0));
    chk({p, "_done_clr"}, 64'(done), 64'(0));
    $display("job %s: error config rejected", p);
  endtask

  function automatic logic any_out();
    return busy | done | error | mem_en_a | mem_en_b | mem_we_a | mem_we_b |
           (|mem_addr_a) | (|mem_addr_b) | (|mem_wdata_a) | (|mem_wdata_b) |
           (|mem_be_a) | (|mem_be_b) | k_start | (|k_din) | k_din_valid |
           k_last_block | k_squeeze;
  endfunction

  initial begin
    // SHA3-256("abc") = 3a985da7 4fe225b2 045c172d 6bd390bd 855f086e 3e9d525b 46bfe245 11431532
    golden_lane[0] = 64'hb225e24fa75d983a;
    golden_lane[1] = 64'hbd90d36b2d175c04;
    golden_lane[2] = 64'h5b529d3e6e085f85;
    golden_lane[3] = 64'h3215431145e2bf46;
    golden_word[0] = 32'ha75d983a; golden_word[1] = 32'hb225e24f;
    golden_word[2] = 32'h2d175c04; golden_word[3] = 32'hbd90d36b;
    golden_word[4] = 32'h6e085f85; golden_word[5] = 32'h5b529d3e;
    golden_word[6] = 32'h45e2bf46; golden_word[7] = 32'h32154311;
    setup_job(17, 1, 32, 16, 160, 0);
    repeat (3) cycle();
    chk("reset_outputs", 64'(any_out()), 64'(0));
    rst_n = 1'b1;
    cycle();
    chk("idle_outputs", 64'(any_out()), 64'(0));

    run_job(17, 1, 32, 16, 160, 1, 0);
    check_job("sha3_256", 17, 0, 8, 160, 32);
    for (int w = 0; w < 8; w++)
      chk("sha3_256_golden", 64'(mem[160 + w]), 64'(golden_word[w]));

    n_kstart = 0;
    repeat (10) cycle();
    chk("hold_no_kstart", 64'(n_kstart), 64'(0));
    chk("hold_busy", 64'(busy), 64'(0));
    chk("hold_done", 64'(done), 64'(1));
    $display("job hold: start high after done, no retrigger");

    run_job(18, 1, 28, 16, 160, 0, 0);
    check_job("sha3_224", 18, 0, 7, 160, 28);

    run_job(21, 3, 200, 16, 160, 0, 0);
    check_job("shake128", 63, 1, 50, 160, 200);

    err_job("err_rate22", 22, 1, 32);
    err_job("err_blocks0", 17, 0, 32);
    err_job("err_outb0", 17, 1, 0);

    run_job(17, 2, 32, 16, 160, 0, 1);
    chk("abort_lane5_reached", 64'(n_rd), 64'(6));
    rst_n = 1'b0;
    #1;
    chk("abort_outputs_zero", 64'(any_out()), 64'(0));
    start = 1'b0;
    cycle();
    chk("abort_outputs_zero_next", 64'(any_out()), 64'(0));
    rst_n = 1'b1;
    repeat (3) cycle();
    chk("abort_no_writes", 64'(n_wr), 64'(0));
    $display("job abort: reset during absorb lane 5");

    run_job(9, 1, 64, 16, 160, 0, 0);
    check_job("post_reset_sha3_512", 9, 0, 16, 160, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/keccak_stream_ctrl.md
Name: keccak_stream_ctrl

Overview:
Parametrised next-generation Keccak accelerator controller.
- Streams an arbitrary number of pre-padded rate blocks from the dual-port accelerator RAM into the keccak core.
- Rate is runtime-selectable, covering SHA3-224/256/384/512 and SHAKE128/256.
- Squeezes an arbitrary-length digest back into RAM, requesting extra permutations when the output exceeds one rate.
- Sits between the accelerator register file (config/status), the local RAM ports a/b, and the keccak core.

Parameters:
ADDR_WIDTH, 32, RAM word-address width.
DATA_WIDTH, 32, RAM word width; fixed at 32 (one 64-bit lane = 2 words).
LEN_WIDTH, 16, width of the block-count and output-byte-count fields.
MAX_RATE_LANES, 21, largest legal rate in 64-bit lanes (168 B, SHAKE128).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; rising edge in IDLE launches a job
rate_lanes  in  5  rate in 64-bit lanes (18/17/13/9 for SHA3, 21/17 for SHAKE)
in_blocks  in  LEN_WIDTH  number of padded rate blocks to absorb
out_bytes  in  LEN_WIDTH  digest length in bytes
in_base  in  ADDR_WIDTH  word address of first input word
out_base  in  ADDR_WIDTH  word address of first output word
busy  out  1  job in progress
done  out  1  job finished; held until start low
error  out  1  illegal configuration; held until start low
mem_en_a/b  out  1  port enables
mem_we_a/b  out  1  write enables
mem_addr_a/b  out  ADDR_WIDTH  word addresses
mem_wdata_a/b  out  32  write data
mem_be_a/b  out  4  byte enables
mem_rdata_a/b  in  32  read data, valid 1 cycle after en
k_start  out  1  one-cycle pulse: core state clear
k_din  out  64  lane to core, {rdata_b, rdata_a}
k_din_valid  out  1  lane valid
k_buffer_full  in  1  core has received a full rate block
k_last_block  out  1  marks the final absorb block
k_ready  in  1  permutation finished, output available
k_dout  in  64  squeezed lane
k_dout_valid  in  1  k_dout valid
k_squeeze  out  1  one-cycle pulse: permute again for more output

Behaviour:
- Reset values: all outputs 0; state IDLE; all counters 0.
- IDLE:
  - On start rising edge, check the configuration.
  - Error condition: rate_lanes==0, rate_lanes>MAX_RATE_LANES, in_blocks==0 or out_bytes==0.
  - If any error condition holds -> ERROR. Otherwise -> INIT.
  - start held high from a previous job does not retrigger.
- INIT: k_start=1 for one cycle; clear lane_cnt, blk_cnt, byte_cnt; busy=1 from this cycle until DONE/ERROR -> ABSORB.
- ABSORB:
  - Each cycle with lane_cnt<rate_lanes: en_a=en_b=1, we=0.
  - Addresses: addr_a = in_base+2*(blk_cnt*rate_lanes+lane_cnt), addr_b = addr_a+1; lane_cnt++.
  - k_din_valid asserts exactly 1 cycle after each read (registered), with k_din={rdata_b,rdata_a}.
  - k_last_block=1 throughout the block where blk_cnt==in_blocks-1.
  - After the last lane issues -> WAIT_FULL.
- WAIT_FULL: no RAM access; on k_buffer_full, blk_cnt++ and lane_cnt=0.
  - If more blocks remain -> ABSORB (next block).
  - Otherwise -> WAIT_PERM.
- WAIT_PERM: on k_ready -> SQUEEZE.
- SQUEEZE:
  - Each k_dout_valid cycle: en_a=en_b=we_a=we_b=1.
  - Addresses: addr_a = out_base+byte_cnt/4, addr_b = addr_a+1; wdata_a=k_dout[31:0], wdata_b=k_dout[63:32].
  - byte_cnt+=8 and sq_lane++.
  - Final lane with partial output (rem = out_bytes-byte_cnt < 8):
    - be_a = mask of min(rem,4) low bytes.
    - be_b = mask of max(rem-4,0) bytes; en_b=0 if rem<=4.
  - k_dout_valid received while byte_cnt>=out_bytes: ignored, no write.
  - When byte_cnt>=out_bytes after a write -> DONE.
  - When sq_lane==rate_lanes and output is still owed: k_squeeze pulse, sq_lane=0 -> WAIT_PERM.
- DONE: done=1, busy=0; on start low -> IDLE.
- ERROR: error=1, done=1, busy=0, no RAM or core activity; on start low -> IDLE.
- Ports a and b are never both writing the same address. Core handshakes are level-sampled on clk.
- Reset asserted mid-job: immediate return to IDLE; no further RAM writes. The core receives k_start on the next job.
- Byte counter width is LEN_WIDTH+1 so 0xFFFF plus overshoot does not wrap.

Test Plan:
- SHA3-256: rate_lanes=17, in_blocks=1, out_bytes=32 -> 17 reads at in_base..+33; k_last_block high; 4 writes with be=F; done; digest matches the golden value for "abc".
- SHA3-224: out_bytes=28 -> last lane writes be_a=F, be_b=0 and en_b=0; no write past out_base+6.
- Multi-block SHAKE128: rate_lanes=21, in_blocks=3, out_bytes=200 -> 63 lanes absorbed; k_last_block only during the third block; one k_squeeze pulse after 168 B; 200 B written; done.
- Errors: rate_lanes=22, then in_blocks=0, then out_bytes=0 -> error=done=1, no mem_en or k_start; start low -> IDLE with error=0.
- Reset during ABSORB lane 5 -> all outputs 0 next cycle; a following valid job completes correctly.
- start held high after DONE -> no retrigger; start toggled low then high -> a second job runs.
